// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the register bank.
package reg_bank_pkg;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
endpackage

// File: rtl/reg_bank_if.sv
// Write/read/clear bus of the register bank.
interface reg_bank_if import reg_bank_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) ();
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clr_req;
  logic              busy;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH/8-1:0] wbe;
  logic [WIDTH-1:0]  wdata;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [WIDTH-1:0]  rdata_a;
  logic [WIDTH-1:0]  rdata_b;

  modport master (
    output clr_req, we, waddr, wbe, wdata, raddr_a, raddr_b,
    input  busy, rdata_a, rdata_b
  );
  modport slave (
    input  clr_req, we, waddr, wbe, wdata, raddr_a, raddr_b,
    output busy, rdata_a, rdata_b
  );
endinterface

// File: rtl/reg_bank_rdport.sv
// One combinational read port: decode, range/R0 masking and same-cycle write bypass.
module reg_bank_rdport import reg_bank_pkg::*; #(
  parameter int  WIDTH   = DEF_WIDTH,
  parameter int  DEPTH   = DEF_DEPTH,
  parameter bit  ZERO_R0 = 1'b1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic [ADDR_W-1:0]           raddr,
  input  logic                        byp_en,
  input  logic [ADDR_W-1:0]           waddr,
  input  logic [WIDTH/8-1:0]          wbe,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata
);
  logic in_range;

  always_comb begin
    in_range = int'(raddr) < DEPTH;
    rdata    = in_range ? mem[raddr] : '0;
    // byp_en already implies waddr is in range and not a dropped R0 write
    if (byp_en && raddr == waddr) begin
      for (int i = 0; i < WIDTH/8; i++)
        if (wbe[i]) rdata[8*i +: 8] = wdata[8*i +: 8];
    end
    if (!in_range || (ZERO_R0 && raddr == '0)) rdata = '0;
  end
endmodule

// File: rtl/reg_bank.sv
// Dual-read, single-write register bank with byte enables and a DEPTH-cycle clear sweep.
module reg_bank import reg_bank_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter bit ZERO_R0 = 1'b1
) (
  input logic       clk,
  input logic       reset,
  reg_bank_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NB     = WIDTH/8;
  localparam int NUM_RP = 2;

  state_t                      state;
  logic [ADDR_W-1:0]           idx;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        wr_ok;
  logic [NUM_RP-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RP-1:0][WIDTH-1:0]  rdata;

  // A write that will commit at the next edge; also gates the read bypass.
  assign wr_ok = bus.we && !bus.clr_req && (state == IDLE) && !reset &&
                 (int'(bus.waddr) < DEPTH) && !(ZERO_R0 && bus.waddr == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem      <= '0;
      state    <= IDLE;
      idx      <= '0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state    <= CLEAR;
            idx      <= '0;
            bus.busy <= 1'b1;
          end else if (wr_ok) begin
            for (int i = 0; i < NB; i++)
              if (bus.wbe[i]) mem[bus.waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
          end
        end
        CLEAR: begin
          mem[idx] <= '0;
          if (idx == ADDR_W'(DEPTH-1)) begin
            state    <= IDLE;
            idx      <= '0;
            bus.busy <= 1'b0;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  assign raddr = {bus.raddr_b, bus.raddr_a};

  for (genvar p = 0; p < NUM_RP; p++) begin : g_rd
    reg_bank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_R0(ZERO_R0)) u_rd (
      .mem   (mem),
      .raddr (raddr[p]),
      .byp_en(wr_ok),
      .waddr (bus.waddr),
      .wbe   (bus.wbe),
      .wdata (bus.wdata),
      .rdata (rdata[p])
    );
  end

  assign bus.rdata_a = rdata[0];
  assign bus.rdata_b = rdata[1];
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 32, number of registers; SHALL be >= 2.
REQ-003 Parameter ZERO_R0, default 1, when 1 register 0 reads as zero and ignores writes.
REQ-004 Derived constant ADDR_W = clog2(DEPTH), not user-overridable.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 clr_req  in  1  one-cycle request to start a clear sweep.
REQ-008 busy  out  1  high while a clear sweep is in progress.
REQ-009 we  in  1  write enable.
REQ-010 waddr  in  ADDR_W  write address.
REQ-011 wbe  in  WIDTH/8  byte-lane write enables; bit i covers data bits 8i+7:8i.
REQ-012 wdata  in  WIDTH  write data.
REQ-013 raddr_a / raddr_b  in  ADDR_W  read addresses, ports A and B.
REQ-014 rdata_a / rdata_b  out  WIDTH  combinational read data, ports A and B.

Function
REQ-015 A write SHALL commit at the rising edge when we=1, busy=0, clr_req=0, and waddr < DEPTH, updating only lanes with wbe bit set; other lanes SHALL be held.
REQ-016 we=1 with wbe=0 SHALL leave the register unchanged.
REQ-017 With ZERO_R0=1, writes to address 0 SHALL be dropped and both ports SHALL read 0 at address 0.
REQ-018 A raddr >= DEPTH SHALL read 0; a waddr >= DEPTH SHALL be dropped.
REQ-019 Reads SHALL have zero latency and be independent per port; both ports may read the same address.
REQ-020 Bypass: when a write qualifies per REQ-015 and raddr equals waddr, rdata SHALL show the merged value (new bytes on enabled lanes, stored bytes elsewhere) in the same cycle.
REQ-021 The state machine SHALL have two states: IDLE and CLEAR.
REQ-022 In IDLE, clr_req=1 SHALL enter CLEAR at the next edge with sweep index 0; a write presented in that same cycle SHALL be dropped (clr_req has priority).
REQ-023 In CLEAR, each cycle SHALL zero register[index] and increment index; after index DEPTH-1 is zeroed, the state SHALL return to IDLE.
REQ-024 busy SHALL equal (state == CLEAR); a sweep lasts exactly DEPTH cycles.
REQ-025 While busy, we SHALL be ignored, clr_req SHALL be ignored (no restart), and reads SHALL return stored contents with no bypass.
REQ-026 The sweep index SHALL be ADDR_W bits wide and SHALL not wrap past DEPTH-1 for non-power-of-two DEPTH.

Reset
REQ-027 reset=1 at an edge SHALL zero every register, set state to IDLE, clear the index, and drive busy=0 from the following cycle.
REQ-028 reset SHALL override clr_req, we, and any sweep in progress; an interrupted sweep SHALL not resume.
REQ-029 While reset is high, rdata SHALL reflect stored contents (0 after the first reset edge) with bypass suppressed.

Structure
REQ-030 Package reg_bank_pkg SHALL hold the state enumeration (IDLE, CLEAR) and default WIDTH/DEPTH constants.
REQ-031 Sub-module reg_bank_rdport (address decode, out-of-range and R0 masking, byte-merge bypass) SHALL be instantiated once per read port.
REQ-032 Storage SHALL be a single DEPTH x WIDTH array written only by the top-level sequential process.

Verification
REQ-033 Reset, then write addr 5 = 0xDEADBEEF with wbe=4'hF; the next cycle raddr_a=5 -> rdata_a=0xDEADBEEF.
REQ-034 With addr 5 = 0xDEADBEEF, write 0x11223344 with wbe=4'b0101 while raddr_b=5 -> same-cycle rdata_b=0xDE22BE44, and stored value 0xDE22BE44 afterwards.
REQ-035 ZERO_R0=1: write addr 0 = 0xFFFFFFFF -> rdata_a at addr 0 = 0 in the same and next cycles.
REQ-036 Fill all 32 registers, pulse clr_req -> busy high for exactly 32 cycles; a write to addr 7 in cycle 3 is dropped; all reads = 0 after busy falls.
REQ-037 Start a sweep, assert reset at sweep cycle 10 -> busy=0 the next cycle, all registers = 0, and clr_req is accepted normally afterwards.
REQ-038 DEPTH=24: write addr 30 -> no register changes; raddr_a=30 -> rdata_a=0; a sweep lasts 24 cycles.
